id_pair_packer: RTL



---
 rtl/id_pair_packer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/id_pair_packer.sv
// id_pair_packer
//
// Packs the ID-pair hit stream from tanimoto_top into fixed SLOT_WIDTH slots
// of BUS_WIDTH-wide words. The words go out on a valid/ready stream with byte
// keep and last, for the result-writeback DMA. The block also reports how many
// pairs were accepted in the current (or most recent) job.
//
// Ports:
//   clk            clock
//   rstn           asynchronous active-low reset
//   i_IDPair_Ready upstream has a pair on i_IDPair_In
//   i_IDPair_In    ID pair, {id_a, id_b}, passed through bit-exact
//   i_IDPair_Last  current pair is the final pair of the job
//   o_IDPair_Read  pop strobe; the pair is taken on a clock edge with this high
//   o_Data         packed output word, slot 0 at the LSBs
//   o_Keep         byte enables of o_Data
//   o_Valid        o_Data/o_Keep/o_Last valid
//   i_Ready        downstream accepts the word
//   o_Last         final word of the job
//   o_PairCount    pairs accepted in the current/most recent job (mod 2^32)
//   o_Done         one-cycle pulse, one cycle after the o_Last word handshake
module id_pair_packer #(
    parameter int BUS_WIDTH    = 128,
    parameter int VEC_ID_WIDTH = 10,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_IDPair_Ready,
    input  logic [2*VEC_ID_WIDTH-1:0] i_IDPair_In,
    input  logic                      i_IDPair_Last,
    output logic                      o_IDPair_Read,
    output logic [BUS_WIDTH-1:0]      o_Data,
    output logic [BUS_WIDTH/8-1:0]    o_Keep,
    output logic                      o_Valid,
    input  logic                      i_Ready,
    output logic                      o_Last,
    output logic [31:0]               o_PairCount,
    output logic                      o_Done
);

    localparam int SLOTS      = BUS_WIDTH / SLOT_WIDTH;
    localparam int KEEP_W     = BUS_WIDTH / 8;
    localparam int SLOT_BYTES = SLOT_WIDTH / 8;
    localparam int SLOT_IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [BUS_WIDTH-1:0]  acc_q, acc_d;
    logic [SLOT_IDX_W-1:0] slot_q, slot_d;
    logic                  job_start_q, job_start_d;
    logic [BUS_WIDTH-1:0]  data_q, data_d;
    logic [KEEP_W-1:0]     keep_q, keep_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;
    logic [31:0]           count_q, count_d;
    logic                  done_q, done_d;

    logic                  completes;
    logic                  out_free;
    logic                  accept;
    logic [SLOT_WIDTH-1:0] slot_word;
    logic [BUS_WIDTH-1:0]  merged;
    logic [KEEP_W-1:0]     keep_mask;

    // A pair closes the current word when it fills the last slot or ends the job.
    assign completes = (slot_q == SLOT_IDX_W'(SLOTS - 1)) || i_IDPair_Last;
    // The holding register can take a new word if it is empty or draining now.
    assign out_free  = !valid_q || i_Ready;
    // Non-completing pairs only touch acc, so they are taken even under backpressure.
    assign accept    = rstn && i_IDPair_Ready && (!completes || out_free);
    assign o_IDPair_Read = accept;

    // Pair zero-extended into its slot; upper slot bits stay 0.
    assign slot_word = SLOT_WIDTH'(i_IDPair_In);

    always_comb begin
        merged    = acc_q;
        keep_mask = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (slot_q == SLOT_IDX_W'(k)) begin
                merged[k*SLOT_WIDTH +: SLOT_WIDTH] = slot_word;
            end
        end
        // Bytes of slots 0..slot are live in a completing word.
        for (int b = 0; b < KEEP_W; b++) begin
            keep_mask[b] = (b < (int'(slot_q) + 1) * SLOT_BYTES);
        end
    end

    always_comb begin
        acc_d       = acc_q;
        slot_d      = slot_q;
        job_start_d = job_start_q;
        data_d      = data_q;
        keep_d      = keep_q;
        last_d      = last_q;
        valid_d     = valid_q;
        count_d     = count_q;
        done_d      = valid_q && i_Ready && last_q;

        if (valid_q && i_Ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            // First pair of a job restarts the count; otherwise it keeps running.
            count_d     = job_start_q ? 32'd1 : count_q + 32'd1;
            job_start_d = i_IDPair_Last;
            if (completes) begin
                // Loading here overrides the drain above: back-to-back words.
                data_d  = merged;
                keep_d  = keep_mask;
                last_d  = i_IDPair_Last;
                valid_d = 1'b1;
                acc_d   = '0;
                slot_d  = '0;
            end else begin
                acc_d  = merged;
                slot_d = slot_q + SLOT_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q       <= '0;
            slot_q      <= '0;
            job_start_q <= 1'b1;
            data_q      <= '0;
            keep_q      <= '0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
            count_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            slot_q      <= slot_d;
            job_start_q <= job_start_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            done_q      <= done_d;
        end
    end

    assign o_Data      = data_q;
    assign o_Keep      = keep_q;
    assign o_Valid     = valid_q;
    assign o_Last      = last_q;
    assign o_PairCount = count_q;
    assign o_Done      = done_q;

endmodule
